// File: rtl/serial_com_pkg.sv
// serial_com_pkg: frame constants and FSM state type shared by the serial transmitter and receiver
package serial_com_pkg;
  localparam int FRAME_BITS = 7;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int NUM_PORTS = 4;
  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, GAP} state_t;
  function automatic logic [ADDR_W-1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (oh[i]) onehot_idx = ADDR_W'(i);
  endfunction
endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: per-port request/data bus plus serial line status of serial_frame_tx
interface serial_frame_tx_if;
  import serial_com_pkg::*;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS*DATA_W-1:0] data;
  logic [NUM_PORTS-1:0] ack;
  logic serial_out;
  logic busy;
  logic [ADDR_W-1:0] grant;
  modport master(output req, data, input ack, serial_out, busy, grant);
  modport slave(input req, data, output ack, serial_out, busy, grant);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter starting after ptr; fixed priority (port 0 highest) with SERIAL_TX_FIXED_PRIO_EN
module rr_arbiter
  import serial_com_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ADDR_W-1:0] ptr,
  output logic [NUM_PORTS-1:0] gnt
);
`ifdef SERIAL_TX_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  always_comb begin
    gnt = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) if (req[i]) gnt = NUM_PORTS'(1) << i;
  end
`else
  logic [ADDR_W-1:0] k;
  // Scan from farthest to nearest so the port right after ptr wins last
  always_comb begin
    gnt = '0;
    k = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      k = ptr + ADDR_W'(i);
      if (req[k]) gnt = NUM_PORTS'(1) << k;
    end
  end
`endif
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: 4-port arbitrated serial transmitter; frame = start 0, 2 addr bits, 4 data bits, GAP_BITS idle.
// Define SERIAL_TX_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module serial_frame_tx
  import serial_com_pkg::*;
#(
  parameter int GAP_BITS = 1
)
(
  input logic clk,
  input logic rst,
  serial_frame_tx_if.slave bus
);
  state_t state, state_n;
  logic [2:0] cnt;
  logic [ADDR_W-1:0] grant, ptr, win;
  logic [DATA_W-1:0] word;
  logic [NUM_PORTS-1:0] gnt;
  logic take;
  rr_arbiter u_arb (.req(bus.req), .ptr(ptr), .gnt(gnt));
  assign win = onehot_idx(gnt);
  assign take = state == IDLE && |bus.req;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = take ? START : IDLE;
      START:   state_n = ADDR;
      ADDR:    state_n = cnt == 3'(ADDR_W-1) ? DATA : ADDR;
      DATA:    state_n = cnt == 3'(DATA_W-1) ? GAP : DATA;
      GAP:     state_n = cnt == 3'(GAP_BITS-1) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      grant <= '0;
      word <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 3'd1;
      if (take) begin
        grant <= win;
        word <= bus.data[win*DATA_W +: DATA_W];
      end
    end
  end
`ifdef SERIAL_TX_FIXED_PRIO_EN
  assign ptr = '1;
`else
  always_ff @(posedge clk) ptr <= !rst ? '1 : take ? win : ptr;
`endif
  assign bus.ack = state == START ? NUM_PORTS'(1) << grant : '0;
  assign bus.busy = state != IDLE;
  assign bus.grant = grant;
  assign bus.serial_out = state == START ? 1'b0 : state == ADDR ? grant[cnt[0]] : state == DATA ? word[cnt[1:0]] : 1'b1;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench; stimulus queues expected frames, per-DUT monitors check them on ack.
module tb_serial_frame_tx;
  import serial_com_pkg::*;
  typedef struct {
    logic [1:0] g;
    logic [6:0] seq;
    int sp;
    bit abort;
  } exp_t;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[2][$];
  logic [3:0] ack_w[2];
  logic so_w[2];
  logic busy_w[2];
  logic [1:0] grant_w[2];
  logic [6:0] rr_seq[4] = '{7'b0001000, 7'b0100100, 7'b0010010, 7'b0110001};
  serial_frame_tx_if bus0 ();
  serial_frame_tx_if bus1 ();
  serial_frame_tx #(.GAP_BITS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  serial_frame_tx #(.GAP_BITS(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  assign ack_w[0] = bus0.ack;
  assign ack_w[1] = bus1.ack;
  assign so_w[0] = bus0.serial_out;
  assign so_w[1] = bus1.serial_out;
  assign busy_w[0] = bus0.busy;
  assign busy_w[1] = bus1.busy;
  assign grant_w[0] = bus0.grant;
  assign grant_w[1] = bus1.grant;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int j, input int lim);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (ack_w[j] == 4'd0 && k < lim);
    if (ack_w[j] == 4'd0) check("ack_timeout", 0, 1);
  endtask

  for (genvar j = 0; j < 2; j++) begin : g_mon
    localparam int G = j ? 3 : 1;
    initial begin
      exp_t e;
      logic [6:0] s;
      int last;
      bit ab;
      last = 0;
      forever begin
        @(negedge clk);
        if (ack_w[j] != 4'd0) begin
          if (exp_q[j].size() == 0) check("ack_unexpected", 32'(ack_w[j]), 0);
          else begin
            e = exp_q[j].pop_front();
            check("ack", 32'(ack_w[j]), 32'(4'd1 << e.g));
            check("grant", 32'(grant_w[j]), 32'(e.g));
            check("busy", 32'(busy_w[j]), 1);
            if (e.sp != 0) check("spacing", cyc - last, e.sp);
            last = cyc;
            s = {6'd0, so_w[j]};
            ab = 0;
            for (int i = 1; i < 7 && !ab; i++) begin
              @(negedge clk);
              if (!rst) ab = 1;
              else begin
                s = {s[5:0], so_w[j]};
                if (i == 1) check("ack_pulse", 32'(ack_w[j]), 0);
              end
            end
            check("abort", 32'(ab), 32'(e.abort));
            if (!ab) begin
              check("bits", 32'(s), 32'(e.seq));
              for (int i = 0; i < G; i++) begin
                @(negedge clk);
                check("gap", 32'({busy_w[j], so_w[j]}), 32'(2'b11));
              end
              @(negedge clk);
              check("idle", 32'({busy_w[j], so_w[j], ack_w[j]}), 32'(6'b010000));
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus0.req = '0;
    bus0.data = '0;
    bus1.req = '0;
    bus1.data = '0;
    step(3);
    for (int j = 0; j < 2; j++) begin
      check("rst_serial", 32'(so_w[j]), 1);
      check("rst_busy", 32'(busy_w[j]), 0);
      check("rst_ack", 32'(ack_w[j]), 0);
      check("rst_grant", 32'(grant_w[j]), 0);
    end
    rst = 1;
    step(1);
    // single request from port 2
    exp_q[0].push_back('{2'd2, 7'b0011101, 0, 1'b0});
    bus0.data = 16'h0B00;
    bus0.req = 4'b0100;
    wait_ack(0, 5);
    bus0.req = '0;
    step(10);
    check("grant_hold", 32'(grant_w[0]), 2);
    // all ports requesting continuously from a fresh reset
    rst = 0;
    step(1);
    rst = 1;
    bus0.data = 16'h8421;
    for (int i = 0; i < 5; i++) begin
`ifdef SERIAL_TX_FIXED_PRIO_EN
      exp_q[0].push_back('{2'd0, rr_seq[0], i ? 9 : 0, 1'b0});
`else
      exp_q[0].push_back('{2'(i % 4), rr_seq[i % 4], i ? 9 : 0, 1'b0});
`endif
    end
    bus0.req = 4'hF;
    wait_ack(0, 5);
    for (int i = 0; i < 4; i++) wait_ack(0, 12);
    bus0.req = '0;
    step(12);
    // reset during DATA of a port-1 frame
    exp_q[0].push_back('{2'd1, 7'b0, 0, 1'b1});
    bus0.data = 16'h0020;
    bus0.req = 4'b0010;
    wait_ack(0, 5);
    bus0.req = '0;
    step(3);
    rst = 0;
    step(1);
    check("abort_serial", 32'(so_w[0]), 1);
    check("abort_busy", 32'(busy_w[0]), 0);
    check("abort_ack", 32'(ack_w[0]), 0);
    step(1);
    check("abort_grant", 32'(grant_w[0]), 0);
    exp_q[0].push_back('{2'd0, rr_seq[0], 0, 1'b0});
    bus0.data = 16'h8421;
    bus0.req = 4'hF;
    rst = 1;
    wait_ack(0, 5);
    bus0.req = '0;
    step(12);
    // port 3 frame with req and data changing right after the latch
    exp_q[0].push_back('{2'd3, 7'b0110110, 0, 1'b0});
    bus0.data = 16'h6000;
    bus0.req = 4'b1000;
    wait_ack(0, 5);
    bus0.req = '0;
    bus0.data = 16'h9FFF;
    step(1);
    bus0.data = 16'h0000;
    step(12);
    // three-bit gap, back-to-back frames
    exp_q[1].push_back('{2'd0, rr_seq[0], 0, 1'b0});
    exp_q[1].push_back('{2'd0, rr_seq[0], 11, 1'b0});
    exp_q[1].push_back('{2'd0, rr_seq[0], 11, 1'b0});
    bus1.data = 16'h0001;
    bus1.req = 4'b0001;
    wait_ack(1, 5);
    wait_ack(1, 14);
    wait_ack(1, 14);
    bus1.req = '0;
    step(16);
    check("q0_empty", exp_q[0].size(), 0);
    check("q1_empty", exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter: GAP_BITS, default 1, number of idle (1) bit-times forced after each frame; legal range 1..7.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset, sampled on rising clk edge only).
REQ-004 req  input  4  per-port send request; req[i] high = port i has a 4-bit word pending.
REQ-005 data  input  16  port i word on data[4i+3:4i].
REQ-006 ack  output  4  one-cycle pulse on ack[i] when port i's word is latched for transmission.
REQ-007 serial_out  output  1  serial line; idles high.
REQ-008 busy  output  1  high while a frame or gap is in progress.
REQ-009 grant  output  2  port index of the frame currently being sent; holds last value when idle.

Function
REQ-010 Frame format SHALL be 7 bit-times, one bit per clk: start 0, addr[0], addr[1], data[0], data[1], data[2], data[3]; then GAP_BITS bit-times of 1.
REQ-011 FSM states SHALL be IDLE, START, ADDR, DATA, GAP; serial_out = 1 in IDLE and GAP.
REQ-012 IDLE: at an edge with req != 0, SHALL pick a winner g, latch data word g and g, and go to START; otherwise stay IDLE.
REQ-013 In the cycle after the latching edge: state START, serial_out = 0, ack[g] = 1, busy = 1, grant = g; ack is 0 in every other cycle.
REQ-014 ADDR SHALL last 2 cycles (addr LSB first); DATA SHALL last 4 cycles (LSB first); GAP SHALL last GAP_BITS cycles; then IDLE.
REQ-015 Minimum start-bit-to-start-bit spacing SHALL be 8 + GAP_BITS cycles (9 with default) under continuous requests.
REQ-016 Arbitration (default) SHALL be round-robin: search starts at (last grant + 1) mod 4 and wraps 3 -> 0.
REQ-017 Changes to req or data after the latching edge SHALL NOT affect the frame in flight.
REQ-018 A port keeping req high after its ack SHALL be treated as a new request at the next IDLE evaluation.
REQ-019 busy SHALL be 0 only in IDLE.
REQ-020 Bit counter SHALL be 3 bits, cleared on every state entry; no wrap beyond the state length.

Reset
REQ-021 When rst = 0 at an edge: state IDLE, serial_out = 1, ack = 0, busy = 0, grant = 0, round-robin pointer = 3 (port 0 wins first).
REQ-022 Reset mid-frame SHALL abandon the frame; line returns high at that edge, and no ack is issued for the abandoned frame after reset.
REQ-023 Reset has priority over all other events in the same cycle.

Configuration
REQ-024 Macro SERIAL_TX_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (port 0 highest, port 3 lowest) and the pointer logic is removed; when undefined, round-robin per REQ-016.

Structure
REQ-025 Package serial_com_pkg SHALL hold the FSM state typedef and constants FRAME_BITS = 7, ADDR_W = 2, DATA_W = 4, NUM_PORTS = 4; the downstream receiver uses the same package.
REQ-026 Arbiter SHALL be a sub-module rr_arbiter (4-bit req, pointer in, one-hot grant out); the fixed-priority variant is selected inside it by the macro.

Verification
REQ-027 Single request: req = 0100, data[11:8] = 1011 -> ack = 0100 for one cycle; serial_out = 0,0,1,1,1,0,1 then 1 for 1 cycle; grant = 2.
REQ-028 All ports request continuously (round-robin): frames granted 0,1,2,3,0 in order; start bits 9 cycles apart.
REQ-029 Same stimulus with SERIAL_TX_FIXED_PRIO_EN defined: every frame granted to port 0.
REQ-030 rst = 0 during DATA of a port-1 frame: serial_out = 1 from that edge; busy = 0; next grant after release is port 0.
REQ-031 data changes and req drops on the cycle after ack (port 3, word 0110): transmitted bits still 0,1,1,0,1,1,0.
REQ-032 GAP_BITS = 3, back-to-back requests: start-bit spacing 11 cycles; line high for 3 cycles plus the IDLE cycle between frames.
